// File: rtl/step_cmd_ctrl_if.sv
// Command channel from the debug host into the step-counter front-end.
// A command moves on any posedge where cmd_valid and cmd_ready are both high.
interface step_cmd_ctrl_if #(
    parameter int ARG_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/step_cmd_ctrl.sv
// Run/step/resume/halt front-end for the gated-clock step counter.
// It owns the cumulative target trg_count and reports run completion on done.
module step_cmd_ctrl #(
    parameter int CNT_W = 64,
    parameter int ARG_W = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    step_cmd_ctrl_if.slave   cmd,
    input  logic             match,
    output logic             active,
    output logic [CNT_W-1:0] trg_count,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic             sat
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_e;
    typedef enum logic [1:0] {OP_RUN, OP_STEP, OP_RESUME, OP_HALT} op_e;

    state_e           state, state_nx;
    op_e              op;
    logic [ARG_W-1:0] arg;
    logic             acc, is_ext, is_free;
    logic [CNT_W-1:0] inc, trg_nx;
    logic [CNT_W:0]   sum;
    logic             done_nx, err_nx, sat_nx;

    assign cmd.cmd_ready = !rst;
    assign op            = op_e'(cmd.cmd_op);
    assign arg           = cmd.cmd_arg;
    assign acc           = cmd.cmd_valid && cmd.cmd_ready;
    assign is_ext        = acc && (op == OP_RUN || op == OP_STEP);
    assign is_free       = (op == OP_RUN) && (arg == '0);
    assign inc           = (op == OP_STEP) ? CNT_W'(1) : CNT_W'(arg);
    // One extra bit catches the carry so the target pins at all-ones instead of wrapping.
    assign sum           = {1'b0, trg_count} + {1'b0, inc};

    always_comb begin
        state_nx = state;
        trg_nx   = trg_count;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        sat_nx   = sat;

        if (is_ext) begin
            if (is_free) begin
                trg_nx = '1;
            end else if (sum[CNT_W]) begin
                trg_nx = '1;
                sat_nx = 1'b1;
            end else begin
                trg_nx = sum[CNT_W-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (is_ext)   state_nx = RUNNING;
                else if (acc) err_nx   = 1'b1;
            end
            RUNNING: begin
                // An extend beats completion; completion beats a same-edge HALT.
                if (!is_ext && match) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (acc && op == OP_HALT) begin
                    state_nx = PAUSED;
                end
                if (acc && op == OP_RESUME) err_nx = 1'b1;
            end
            PAUSED: begin
                if (acc && op == OP_RESUME)    state_nx = RUNNING;
                else if (acc && op == OP_HALT) err_nx   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            trg_count <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_nx;
            trg_count <= trg_nx;
            done      <= done_nx;
            cmd_err   <= err_nx;
            sat       <= sat_nx;
        end
    end

    assign active = (state == RUNNING);
    assign busy   = (state != IDLE);
endmodule
